// File: rtl/memory_pkg.sv
// Shared types and address helpers for the banked byte memory.
// Lanes are byte banks. A byte address splits into a lane index and a word index.
package memory_pkg;

    typedef enum logic {INIT, RUN} mem_state_t;

    function automatic int n_bits(input int nb);
        return 8 * nb;
    endfunction

    function automatic int addr_bits(input int m, input int nb);
        return m + $clog2(nb);
    endfunction

    function automatic int unsigned lane_of(input int unsigned addr, input int unsigned nb);
        return addr % nb;
    endfunction

    function automatic int unsigned word_of(input int unsigned addr, input int unsigned nb);
        return addr / nb;
    endfunction

endpackage

// File: rtl/banked_byte_memory_if.sv
// Request/response bus between the core memory stage and the byte memory.
interface banked_byte_memory_if
    import memory_pkg::*;
#(
    parameter int M  = 10,
    parameter int NB = 4
);
    localparam int N  = n_bits(NB);
    localparam int AW = addr_bits(M, NB);

    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [N-1:0]  req_mask;
    logic [N-1:0]  req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_rdata;

    modport master (
        output req_valid, req_addr, req_mask, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_mask, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_lane.sv
// One byte-wide bank: single-port synchronous RAM with a bit mask and write-first readback.
module mem_lane #(
    parameter int M = 10
) (
    input  logic         clk,
    input  logic         we,
    input  logic [M-1:0] word_addr,
    input  logic [7:0]   bit_mask,
    input  logic [7:0]   wdata,
    output logic [7:0]   rdata
);
    logic [7:0] mem [2**M];
    logic [7:0] merged;

    assign merged = (mem[word_addr] & ~bit_mask) | (wdata & bit_mask);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[word_addr] <= merged;
        end
        rdata <= we ? merged : mem[word_addr];
    end
endmodule

// File: rtl/banked_byte_memory.sv
// Byte-addressed memory made of NB byte lanes. It supports unaligned single-cycle access,
// a bit-level write mask, and a clear sweep that runs after reset or on request.
//
//   state | meaning
//   INIT  | clear sweep writes zero to word cnt_q in every lane; busy=1, no requests
//   RUN   | serve requests; clr restarts the sweep
module banked_byte_memory
    import memory_pkg::*;
#(
    parameter int M  = 10,
    parameter int NB = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    output logic                 busy,
    banked_byte_memory_if.slave  bus
);
    localparam int N  = n_bits(NB);
    localparam int AW = addr_bits(M, NB);
    localparam int LB = $clog2(NB);

    mem_state_t    state_q, state_d;
    logic [M-1:0]  cnt_q, cnt_d;
    logic          accept;
    logic          rsp_valid_q, fresh_q;
    logic [LB-1:0] rot_q;
    logic [N-1:0]  hold_q, rdata_asm;
    logic [7:0]    lane_rdata [NB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            INIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign bus.req_ready = (state_q == RUN) && (!rsp_valid_q || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    // Lane l carries access byte k = (l - addr) mod NB, so each lane gets its own word index.
    for (genvar l = 0; l < NB; l++) begin : g_lane
        logic [LB-1:0] k;
        logic [AW-1:0] a;

        assign k = LB'(l) - bus.req_addr[LB-1:0];
        assign a = bus.req_addr + AW'(k);

        mem_lane #(.M(M)) u_lane (
            .clk       (clk),
            .we        ((state_q == INIT) || accept),
            .word_addr ((state_q == INIT) ? cnt_q : M'(word_of(32'(a), NB))),
            .bit_mask  ((state_q == INIT) ? 8'hFF : bus.req_mask[N-1-8*k -: 8]),
            .wdata     ((state_q == INIT) ? 8'h00 : bus.req_wdata[N-1-8*k -: 8]),
            .rdata     (lane_rdata[l])
        );
    end

    for (genvar k = 0; k < NB; k++) begin : g_rot
        assign rdata_asm[N-1-8*k -: 8] = lane_rdata[LB'(lane_of(32'(rot_q) + k, NB))];
    end

    // Lane outputs are only valid the cycle after an access; hold_q snapshots them so the
    // response survives later lane traffic, including a clear sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            fresh_q     <= 1'b0;
            rot_q       <= '0;
            hold_q      <= '0;
        end else begin
            if (fresh_q) begin
                hold_q <= rdata_asm;
            end
            fresh_q <= accept;
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rot_q       <= bus.req_addr[LB-1:0];
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = fresh_q ? rdata_asm : hold_q;
endmodule

// File: tb/tb_banked_byte_memory.sv
// Directed checks of banked_byte_memory with 16 words of 4 bytes: clear sweep, masking,
// misaligned and wrapping access, backpressure, clr and mid-sweep reset.
module tb_banked_byte_memory;
    localparam int M  = 4;
    localparam int NB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic busy;

    int n_chk  = 0;
    int n_fail = 0;

    banked_byte_memory_if #(.M(M), .NB(NB)) bus ();

    banked_byte_memory #(.M(M), .NB(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Call at a negedge. Issues one request with rsp_ready=1 and checks the response one
    // edge later.
    task automatic do_req(input string tag, input logic [5:0] a, input logic [31:0] m,
                          input logic [31:0] wd, input logic [31:0] exp);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_mask  = m;
        bus.req_wdata = wd;
        bus.rsp_ready = 1'b1;
        #1;
        chk({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "/rdata"}, bus.rsp_rdata, exp);
        bus.req_valid = 1'b0;
    endtask

    // Call at the first negedge of a sweep. Counts busy cycles and optionally checks that a
    // pending response is held, or pokes clr mid-sweep.
    task automatic wait_init(input string tag, input bit hold_rsp, input logic [31:0] held,
                             input bit poke_clr);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            chk({tag, "/req_ready_low"}, 32'(bus.req_ready), 32'd0);
            if (hold_rsp) begin
                chk({tag, "/held_valid"}, 32'(bus.rsp_valid), 32'd1);
                chk({tag, "/held_rdata"}, bus.rsp_rdata, held);
            end
            clr = poke_clr && (n == 3);
            n++;
            @(negedge clk);
        end
        clr = 1'b0;
        chk({tag, "/busy_cycles"}, 32'(n), 32'd16);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_mask  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst/busy", 32'(busy), 32'd1);
        chk("rst/req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst/rsp_rdata", bus.rsp_rdata, 32'h0);

        rst_n = 1'b1;
        wait_init("init1", 1'b0, 32'h0, 1'b0);
        do_req("rd3c", 6'h3C, 32'h0, 32'h0, 32'h0000_0000);

        do_req("wr08", 6'h08, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_req("rd0a", 6'h0A, 32'h0, 32'h0, 32'hBEEF_0000);

        do_req("mask08", 6'h08, 32'h0000_FF0F, 32'h0, 32'hDEAD_00E0);

        do_req("wr3e", 6'h3E, 32'hFFFF_FFFF, 32'h1122_3344, 32'h1122_3344);
        do_req("rd00", 6'h00, 32'h0, 32'h0, 32'h3344_0000);
        do_req("rd3c_wrap", 6'h3C, 32'h0, 32'h0, 32'h0000_1122);

        // Backpressure: the first response stalls while a second request waits.
        @(negedge clk);
        chk("bp/idle_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp/idle_rdata", bus.rsp_rdata, 32'h0000_1122);
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'h08;
        bus.req_mask  = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_addr = 6'h3E;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp/valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp/rdata", bus.rsp_rdata, 32'hDEAD_00E0);
            chk("bp/req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp/release_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("bp/next_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp/next_rdata", bus.rsp_rdata, 32'h1122_3344);
        bus.req_valid = 1'b0;

        // clr in the same cycle as a write: the write completes, then the sweep erases it.
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'h10;
        bus.req_mask  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'hCAFE_F00D;
        clr = 1'b1;
        #1;
        chk("clr/req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        clr = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        chk("clr/rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("clr/rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        wait_init("init2", 1'b1, 32'hCAFE_F00D, 1'b1);
        chk("clr/held_after", bus.rsp_rdata, 32'hCAFE_F00D);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("clr/drop_valid", 32'(bus.rsp_valid), 32'd0);
        chk("clr/keep_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        do_req("rd10_clr", 6'h10, 32'h0, 32'h0, 32'h0000_0000);
        do_req("rd08_clr", 6'h08, 32'h0, 32'h0, 32'h0000_0000);

        // Pending response, then clr, then reset partway through the sweep.
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'h3E;
        bus.req_mask  = 32'h0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("mid/busy", 32'(busy), 32'd1);
        chk("mid/pending", 32'(bus.rsp_valid), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid/rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid/rst_rdata", bus.rsp_rdata, 32'h0);
        chk("mid/rst_busy", 32'(busy), 32'd1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init3", 1'b0, 32'h0, 1'b0);
        chk("mid/after_valid", 32'(bus.rsp_valid), 32'd0);
        do_req("rd3c_final", 6'h3C, 32'h0, 32'h0, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
